// File: rtl/disp_scan.sv
// Time-multiplexed 7-segment digit scanner: rotates through DIGITS nibbles at a
// fixed slot rate and swaps in newly loaded values only on frame boundaries.
module disp_scan #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic                  JM1222HM_clk,
  input  logic                  JM1222HM_rst_n,
  input  logic                  JM1222HM_load,
  input  logic [4*DIGITS-1:0]   JM1222HM_value,
  input  logic                  JM1222HM_blank_lz,
  output logic [3:0]            JM1222HM_nibble,
  output logic [DIGITS-1:0]     JM1222HM_an_n,
  output logic                  JM1222HM_blank,
  output logic                  JM1222HM_done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VW = 4 * DIGITS;

  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     disp_q, disp_d;
  logic [VW-1:0]     pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic [3:0]        nibble_q, nibble_d;
  logic [DIGITS-1:0] an_n_q, an_n_d;
  logic              blank_q, blank_d;
  logic              done_q, done_d;
  logic              tick_c, frame_c, lz_c;

  // Slot timing, pending-value capture and frame-boundary transfer
  always_comb begin
    tick_c   = (pcnt_q == PW'(PRESCALE - 1));
    frame_c  = tick_c && (idx_q == IW'(DIGITS - 1));
    pcnt_d   = tick_c ? '0 : pcnt_q + PW'(1);
    idx_d    = idx_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    done_d   = 1'b0;

    if (tick_c) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    // A load in the boundary cycle is captured after the old pend transfers.
    if (frame_c && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
      done_d   = 1'b1;
    end
    if (JM1222HM_load) begin
      pend_d   = JM1222HM_value;
      pend_v_d = 1'b1;
    end
  end

  // Slot outputs; lz_c tracks "all nibbles from the top down to i are zero"
  always_comb begin
    nibble_d = 4'h0;
    an_n_d   = '1;
    blank_d  = 1'b0;
    lz_c     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IW'(i)) begin
        nibble_d  = disp_q[4*i +: 4];
        an_n_d[i] = 1'b0;
      end
    end
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      lz_c = lz_c && (disp_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        blank_d = JM1222HM_blank_lz && lz_c;
      end
    end
  end

  always_ff @(posedge JM1222HM_clk or negedge JM1222HM_rst_n) begin
    if (!JM1222HM_rst_n) begin
      pcnt_q   <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      nibble_q <= 4'h0;
      an_n_q   <= '1;
      blank_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      nibble_q <= nibble_d;
      an_n_q   <= an_n_d;
      blank_q  <= blank_d;
      done_q   <= done_d;
    end
  end

  assign JM1222HM_nibble = nibble_q;
  assign JM1222HM_an_n   = an_n_q;
  assign JM1222HM_blank  = blank_q;
  assign JM1222HM_done   = done_q;

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan: directed scenarios plus random loads, compared every
// cycle against a cycle-count based model of the scanner.
module tb_disp_scan;

  localparam int unsigned D  = 4;
  localparam int unsigned P  = 4;
  localparam int unsigned D2 = 8;
  localparam int unsigned P2 = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  nibble;
  logic [3:0]  an_n;
  logic        blank;
  logic        done;

  logic [31:0] value2 = '0;
  logic [3:0]  nibble2;
  logic [7:0]  an_n2;
  logic        blank2;
  logic        done2;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // Model: cycles since reset release, displayed, pending and pending-valid
  int unsigned cyc = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_pv = 1'b0;

  always #5 clk = ~clk;

  disp_scan #(.DIGITS(D), .PRESCALE(P)) dut (
    .JM1222HM_clk(clk), .JM1222HM_rst_n(rst_n), .JM1222HM_load(load),
    .JM1222HM_value(value), .JM1222HM_blank_lz(blank_lz),
    .JM1222HM_nibble(nibble), .JM1222HM_an_n(an_n),
    .JM1222HM_blank(blank), .JM1222HM_done(done)
  );

  disp_scan #(.DIGITS(D2), .PRESCALE(P2)) dut8 (
    .JM1222HM_clk(clk), .JM1222HM_rst_n(rst_n), .JM1222HM_load(1'b0),
    .JM1222HM_value(value2), .JM1222HM_blank_lz(1'b0),
    .JM1222HM_nibble(nibble2), .JM1222HM_an_n(an_n2),
    .JM1222HM_blank(blank2), .JM1222HM_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_reset_outputs();
    check("rst_nibble", 32'(nibble), 32'h0);
    check("rst_an_n", 32'(an_n), 32'hF);
    check("rst_blank", 32'(blank), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_an_n8", 32'(an_n2), 32'hFF);
  endtask

  // Called at a negedge: drive inputs, predict, clock once, compare, return at negedge
  task automatic step(input logic ld, input logic [15:0] val, input logic blz);
    int unsigned slot, slot2;
    logic        bnd;
    logic [15:0] upper;
    logic [3:0]  e_nib, e_an;
    logic [7:0]  e_an2;
    logic        e_blank, e_done;
    load = ld; value = val; blank_lz = blz;
    slot    = (cyc / P) % D;
    slot2   = (cyc / P2) % D2;
    bnd     = (cyc % (D * P)) == (D * P - 1);
    upper   = m_disp >> (4 * slot);
    e_nib   = upper[3:0];
    e_an    = ~(4'b0001 << slot);
    e_an2   = ~(8'b0000_0001 << slot2);
    e_blank = blz && (slot != 0) && (upper == 16'h0);
    e_done  = bnd && m_pv;
    if (bnd && m_pv) begin
      m_disp = m_pend;
      m_pv   = 1'b0;
    end
    if (ld) begin
      m_pend = val;
      m_pv   = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
    check("nibble", 32'(nibble), 32'(e_nib));
    check("an_n", 32'(an_n), 32'(e_an));
    check("blank", 32'(blank), 32'(e_blank));
    check("done", 32'(done), 32'(e_done));
    check("an_n8", 32'(an_n2), 32'(e_an2));
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int unsigned n, input logic blz);
    for (int i = 0; i < int'(n); i++) step(1'b0, 16'h0, blz);
  endtask

  task automatic run_to_phase(input int unsigned ph, input logic blz);
    for (int i = 0; i < int'(D * P); i++) begin
      if ((cyc % (D * P)) == ph) break;
      step(1'b0, 16'h0, blz);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    cyc = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rv;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Rotation with nothing loaded
    idle(20, 1'b0);

    // Basic load mid-frame
    run_to_phase(6, 1'b0);
    step(1'b1, 16'h12A4, 1'b0);
    idle(2 * D * P, 1'b0);

    // Leading-zero blanking
    step(1'b1, 16'h0030, 1'b1);
    idle(2 * D * P, 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    idle(2 * D * P, 1'b1);
    idle(D * P, 1'b0);

    // Overwrite within one frame
    run_to_phase(1, 1'b0);
    step(1'b1, 16'h1111, 1'b0);
    idle(5, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    idle(2 * D * P, 1'b0);

    // Load in the boundary cycle while another value is pending
    run_to_phase(10, 1'b0);
    step(1'b1, 16'h5678, 1'b0);
    run_to_phase(D * P - 1, 1'b0);
    step(1'b1, 16'h3333, 1'b0);
    idle(2 * D * P, 1'b0);

    // Best-case latency: load one cycle before the boundary tick
    run_to_phase(D * P - 2, 1'b0);
    step(1'b1, 16'h9ABC, 1'b0);
    idle(D * P, 1'b0);

    // Reset mid-frame discards a pending value
    run_to_phase(3, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0);
    idle(4, 1'b0);
    apply_reset();
    idle(3 * D * P, 1'b0);

    // Random loads and blanking-control toggles
    for (int i = 0; i < 1500; i++) begin
      rv = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      step($urandom_range(0, 9) == 0, rv, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
